// File: rtl/gesture_pkg.sv
// Shared definitions for the gesture pipeline: coordinate width, FSM state encoding
// and the default image geometry also used by finger identification.
package gesture_pkg;

  localparam int PIX_W = 8;

  localparam int DEFAULT_IMAGE_WIDTH  = 160;
  localparam int DEFAULT_IMAGE_HEIGHT = 120;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SCAN  = 2'd1;
  localparam state_t ST_FINAL = 2'd2;

  function automatic logic [PIX_W-1:0] span(input logic [PIX_W-1:0] lo,
                                            input logic [PIX_W-1:0] hi);
    return hi - lo + PIX_W'(1);
  endfunction

endpackage

// File: rtl/palm_raster_counter.sv
// Raster position tracker: holds the (row, col) that the next non-SOF pixel beat
// will occupy, and flags the end of a row and the last pixel of the frame.
module palm_raster_counter
  import gesture_pkg::*;
#(
  parameter int IMAGE_WIDTH  = DEFAULT_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = DEFAULT_IMAGE_HEIGHT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load_first,
  input  logic             i_step,
  output logic [PIX_W-1:0] o_row,
  output logic [PIX_W-1:0] o_col,
  output logic             o_at_row_end,
  output logic             o_at_last
);

  localparam logic [PIX_W-1:0] COL_LAST = PIX_W'(IMAGE_WIDTH - 1);
  localparam logic [PIX_W-1:0] ROW_LAST = PIX_W'(IMAGE_HEIGHT - 1);

  logic [PIX_W-1:0] r_row;
  logic [PIX_W-1:0] r_col;

  // The SOF beat itself is (0,0), so the following beat lands on (0,1).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_load_first) begin
      r_row <= '0;
      r_col <= PIX_W'(1);
    end else if (i_step) begin
      if (r_col == COL_LAST) begin
        r_col <= '0;
        r_row <= (r_row == ROW_LAST) ? '0 : r_row + PIX_W'(1);
      end else begin
        r_col <= r_col + PIX_W'(1);
      end
    end
  end

  assign o_row        = r_row;
  assign o_col        = r_col;
  assign o_at_row_end = (r_col == COL_LAST);
  assign o_at_last    = (r_col == COL_LAST) && (r_row == ROW_LAST);

endmodule

// File: rtl/palm_bbox_extractor.sv
// Palm bounding-box extractor over a raster binary skin mask.
// Optional run-length noise filter enabled by defining PALM_NOISE_FILTER_EN.
module palm_bbox_extractor
  import gesture_pkg::*;
#(
  parameter int IMAGE_WIDTH  = DEFAULT_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = DEFAULT_IMAGE_HEIGHT,
  parameter int MIN_RUN      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_valid,
  input  logic             pix_sof,
  input  logic             pix_data,
  output logic [PIX_W-1:0] start_of_palm_r,
  output logic [PIX_W-1:0] start_of_palm_c,
  output logic [PIX_W-1:0] end_of_palm_r,
  output logic [PIX_W-1:0] end_of_palm_c,
  output logic [PIX_W-1:0] palm_width,
  output logic [PIX_W-1:0] palm_height,
  output logic             bbox_valid,
  output logic             frame_err
);

  state_t r_state;

  logic             w_in_frame;
  logic             w_sof_beat;
  logic             w_step;
  logic             w_accept;
  logic [PIX_W-1:0] w_row;
  logic [PIX_W-1:0] w_col;
  logic             w_at_row_end;
  logic             w_at_last;
  logic [PIX_W-1:0] w_pix_r;
  logic [PIX_W-1:0] w_pix_c;
  logic             w_row_end;
  logic             w_last;
  logic             w_qual;
  logic [PIX_W-1:0] w_c_start;

  logic [PIX_W-1:0] r_min_r;
  logic [PIX_W-1:0] r_max_r;
  logic [PIX_W-1:0] r_min_c;
  logic [PIX_W-1:0] r_max_c;
  logic             r_any;

  // A SOF beat starts a frame from IDLE or restarts one from SCAN; FINAL drops it.
  assign w_in_frame = (r_state == ST_IDLE) || (r_state == ST_SCAN);
  assign w_sof_beat = pix_valid && pix_sof && w_in_frame;
  assign w_step     = pix_valid && !pix_sof && (r_state == ST_SCAN);
  assign w_accept   = w_sof_beat || w_step;

  palm_raster_counter #(
    .IMAGE_WIDTH (IMAGE_WIDTH),
    .IMAGE_HEIGHT(IMAGE_HEIGHT)
  ) u_raster (
    .clk         (clk),
    .rst         (rst),
    .i_load_first(w_sof_beat),
    .i_step      (w_step),
    .o_row       (w_row),
    .o_col       (w_col),
    .o_at_row_end(w_at_row_end),
    .o_at_last   (w_at_last)
  );

  assign w_pix_r   = pix_sof ? '0 : w_row;
  assign w_pix_c   = pix_sof ? '0 : w_col;
  assign w_row_end = w_step && w_at_row_end;
  assign w_last    = w_step && w_at_last;

`ifdef PALM_NOISE_FILTER_EN
  localparam logic [PIX_W-1:0] RUN_MAX = PIX_W'(MIN_RUN);
  localparam logic [PIX_W-1:0] RUN_TH  = PIX_W'(MIN_RUN - 1);

  logic [PIX_W-1:0] r_run;
  logic [PIX_W-1:0] w_run_prev;
  logic             w_first_q;

  // Run length saturates at MIN_RUN; reaching MIN_RUN-1 beforehand marks the
  // pixel that retroactively qualifies the whole run.
  assign w_run_prev = w_sof_beat ? '0 : r_run;
  assign w_first_q  = w_accept && pix_data && (w_run_prev == RUN_TH);
  assign w_qual     = w_accept && pix_data && (w_run_prev >= RUN_TH);
  assign w_c_start  = w_first_q ? (w_pix_c - RUN_TH) : w_pix_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_run <= '0;
    end else if (w_accept) begin
      if (!pix_data || w_row_end) begin
        r_run <= '0;
      end else if (w_run_prev < RUN_MAX) begin
        r_run <= w_run_prev + PIX_W'(1);
      end else begin
        r_run <= w_run_prev;
      end
    end
  end
`else
  wire w_unused_min_run = (MIN_RUN > 0);

  assign w_qual    = w_accept && pix_data;
  assign w_c_start = w_pix_c;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_min_r <= '1;
      r_max_r <= '0;
      r_min_c <= '1;
      r_max_c <= '0;
      r_any   <= 1'b0;
    end else if (w_sof_beat) begin
      // New frame: any partial state is discarded, seeded by this (0,0) beat.
      r_min_r <= w_qual ? w_pix_r   : '1;
      r_max_r <= w_qual ? w_pix_r   : '0;
      r_min_c <= w_qual ? w_c_start : '1;
      r_max_c <= w_qual ? w_pix_c   : '0;
      r_any   <= w_qual;
    end else if (w_step && w_qual) begin
      if (w_pix_r < r_min_r)   r_min_r <= w_pix_r;
      if (w_pix_r > r_max_r)   r_max_r <= w_pix_r;
      if (w_c_start < r_min_c) r_min_c <= w_c_start;
      if (w_pix_c > r_max_c)   r_max_c <= w_pix_c;
      r_any <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      start_of_palm_r <= '0;
      start_of_palm_c <= '0;
      end_of_palm_r   <= '0;
      end_of_palm_c   <= '0;
      palm_width      <= '0;
      palm_height     <= '0;
      bbox_valid      <= 1'b0;
      frame_err       <= 1'b0;
    end else begin
      bbox_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_sof_beat) r_state <= ST_SCAN;
        end
        ST_SCAN: begin
          if (pix_valid && pix_sof) begin
            frame_err <= 1'b1;
          end else if (w_last) begin
            r_state <= ST_FINAL;
          end
        end
        ST_FINAL: begin
          if (r_any) begin
            start_of_palm_r <= r_min_r;
            start_of_palm_c <= r_min_c;
            end_of_palm_r   <= r_max_r;
            end_of_palm_c   <= r_max_c;
            palm_width      <= span(r_min_c, r_max_c);
            palm_height     <= span(r_min_r, r_max_r);
          end else begin
            start_of_palm_r <= '0;
            start_of_palm_c <= '0;
            end_of_palm_r   <= '0;
            end_of_palm_c   <= '0;
            palm_width      <= '0;
            palm_height     <= '0;
          end
          bbox_valid <= 1'b1;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_palm_bbox_extractor.sv
// Self-checking bench for palm_bbox_extractor on a reduced 80x60 raster so that
// all frame scenarios fit a short run; expectations follow the PALM_NOISE_FILTER_EN build.
module tb_palm_bbox_extractor;
  import gesture_pkg::*;

  localparam int W    = 80;
  localparam int H    = 60;
  localparam int NPIX = W * H;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_valid = 1'b0;
  logic       pix_sof = 1'b0;
  logic       pix_data = 1'b0;
  logic [7:0] start_of_palm_r, start_of_palm_c, end_of_palm_r, end_of_palm_c;
  logic [7:0] palm_width, palm_height;
  logic       bbox_valid, frame_err;

  palm_bbox_extractor #(
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H),
    .MIN_RUN     (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pix_valid      (pix_valid),
    .pix_sof        (pix_sof),
    .pix_data       (pix_data),
    .start_of_palm_r(start_of_palm_r),
    .start_of_palm_c(start_of_palm_c),
    .end_of_palm_r  (end_of_palm_r),
    .end_of_palm_c  (end_of_palm_c),
    .palm_width     (palm_width),
    .palm_height    (palm_height),
    .bbox_valid     (bbox_valid),
    .frame_err      (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sr, sc, er, ec, w, h;
  } exp_t;

  typedef struct {
    int r0, r1, c0, c1;
    bit rect_en, iso_en, run_en;
    exp_t e;
  } vec_t;

  exp_t q[$];
  exp_t m_e;
  exp_t held;
  vec_t vecs[4];

  int n_checks = 0;
  int n_pass   = 0;
  int n_bbox   = 0;
  int n_err    = 0;
  int cyc      = 0;
  int last_accept = 0;

  int s_r0, s_r1, s_c0, s_c1;
  bit s_rect, s_iso, s_run;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic bit fg(input int r, input int c);
    bit v = 1'b0;
    if (s_rect && r >= s_r0 && r <= s_r1 && c >= s_c0 && c <= s_c1) v = 1'b1;
    if (s_run && r == H - 1 && c >= W - 4) v = 1'b1;
    if (s_iso && ((r == 3 && c == 50) || (r == 50 && (c == 5 || c == 6)))) v = 1'b1;
    return v;
  endfunction

  task automatic set_scene(input vec_t v);
    s_r0 = v.r0; s_r1 = v.r1; s_c0 = v.c0; s_c1 = v.c1;
    s_rect = v.rect_en; s_iso = v.iso_en; s_run = v.run_en;
  endtask

  task automatic drive_beats(input int first, input int n, input bit gaps);
    for (int i = first; i < first + n; i++) begin
      if (gaps) begin
        int g;
        g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        repeat (g) begin
          @(posedge clk); #1;
          pix_valid = 1'b0; pix_sof = 1'b0; pix_data = 1'b0;
        end
      end
      @(posedge clk); #1;
      pix_valid = 1'b1;
      pix_sof   = (i == 0);
      pix_data  = fg(i / W, i % W);
      if (i == NPIX - 1) last_accept = cyc + 1;
    end
    @(posedge clk); #1;
    pix_valid = 1'b0; pix_sof = 1'b0; pix_data = 1'b0;
  endtask

  task automatic wait_result();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    check("result_arrived", q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (bbox_valid) begin
      n_bbox++;
      if (q.size() == 0) begin
        check("unexpected_bbox", 1, 0);
      end else begin
        m_e = q.pop_front();
        check("start_r", int'(start_of_palm_r), m_e.sr);
        check("start_c", int'(start_of_palm_c), m_e.sc);
        check("end_r",   int'(end_of_palm_r),   m_e.er);
        check("end_c",   int'(end_of_palm_c),   m_e.ec);
        check("width",   int'(palm_width),      m_e.w);
        check("height",  int'(palm_height),     m_e.h);
        check("latency", cyc - last_accept, 1);
        held = m_e;
      end
    end
    if (frame_err) begin
      n_err++;
      check("hold_start_r_on_err", int'(start_of_palm_r), held.sr);
      check("hold_end_c_on_err",   int'(end_of_palm_c),   held.ec);
      check("hold_width_on_err",   int'(palm_width),      held.w);
    end
  end

  initial begin
    held = '{0, 0, 0, 0, 0, 0};
    vecs[0] = '{10, 39, 15, 44, 1'b1, 1'b0, 1'b0, '{10, 15, 39, 44, 30, 30}};
    vecs[1] = '{0, 0, 0, 0, 1'b0, 1'b0, 1'b0, '{0, 0, 0, 0, 0, 0}};
    vecs[2] = '{0, 0, 0, 0, 1'b0, 1'b0, 1'b1, '{59, 76, 59, 79, 4, 1}};
`ifdef PALM_NOISE_FILTER_EN
    vecs[3] = '{10, 39, 15, 44, 1'b1, 1'b1, 1'b0, '{10, 15, 39, 44, 30, 30}};
`else
    vecs[3] = '{10, 39, 15, 44, 1'b1, 1'b1, 1'b0, '{3, 5, 50, 50, 46, 48}};
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_start_r", int'(start_of_palm_r), 0);
    check("rst_start_c", int'(start_of_palm_c), 0);
    check("rst_end_r",   int'(end_of_palm_r),   0);
    check("rst_end_c",   int'(end_of_palm_c),   0);
    check("rst_width",   int'(palm_width),      0);
    check("rst_height",  int'(palm_height),     0);
    check("rst_bbox_valid", int'(bbox_valid),   0);
    check("rst_frame_err",  int'(frame_err),    0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Full frames: rectangle, empty, corner run, rectangle plus isolated pixels.
    for (int k = 0; k < 4; k++) begin
      set_scene(vecs[k]);
      q.push_back(vecs[k].e);
      drive_beats(0, NPIX, 1'b0);
      wait_result();
    end

    // Early SOF after 1250 beats of a frame that would widen the box if kept.
    set_scene(vecs[3]);
    drive_beats(0, 1250, 1'b0);
    s_rect = 1'b1; s_iso = 1'b0; s_run = 1'b0;
    s_r0 = 30; s_r1 = 59; s_c0 = 70; s_c1 = 79;
    q.push_back('{30, 70, 59, 79, 10, 30});
    drive_beats(0, NPIX, 1'b0);
    wait_result();
    check("frame_err_count", n_err, 1);

    // Reset mid-frame, tail of the aborted frame without SOF, then a gapped frame.
    set_scene(vecs[0]);
    drive_beats(0, 2000, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    held = '{0, 0, 0, 0, 0, 0};
    @(negedge clk);
    check("midrst_start_r", int'(start_of_palm_r), 0);
    check("midrst_end_c",   int'(end_of_palm_c),   0);
    check("midrst_width",   int'(palm_width),      0);
    check("midrst_height",  int'(palm_height),     0);
    drive_beats(2000, 1000, 1'b0);
    repeat (5) @(negedge clk);
    check("no_bbox_after_abort", n_bbox, 5);
    q.push_back(vecs[0].e);
    drive_beats(0, NPIX, 1'b1);
    wait_result();

    check("bbox_pulse_count", n_bbox, 6);
    check("frame_err_total",  n_err, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
